clock_mode_ctrl: RTL and testbench
==================================

# clock_mode_ctrl

Mode controller for the alarm clock. It conditions the two push buttons and sequences time-set and alarm-set entry through a registered state machine. It also issues one-cycle load strobes (with a validated BCD value) to the timekeeping core, drives display source selection, and owns the buzzer enable with dismiss and timeout. It sits between the board inputs (KEY0, KEY1, SW) and the clock/alarm counters, replacing the ad-hoc button-edge toggles used for entering set modes.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronized button must be stable before a press is accepted (20 ms at 50 MHz)
- BUZZ_TIMEOUT_S, 60, seconds the buzzer stays on without a dismiss
- CLOCK_50  in  1  system clock, all logic rising-edge
- RESET_N  in  1  asynchronous, active-low reset
- KEY0  in  1  mode button, active-low, asynchronous to CLOCK_50
- KEY1  in  1  set/dismiss button, active-low, asynchronous
- ALARM_EN  in  1  alarm arm switch (SW[9]), level
- SET_IN  in  8  BCD entry value, [7:4] tens, [3:0] ones (SW[7:0])
- SEC_TICK  in  1  one-cycle pulse per second from the timekeeping core
- ALARM_MATCH  in  1  level, high while current HH:MM equals alarm HH:MM
- MODE  out  3  current state encoding
- LOAD_HOUR, LOAD_MIN, LOAD_A_HOUR, LOAD_A_MIN  out  1 each  one-cycle load strobes
- LOAD_VALUE  out  8  BCD value qualified by any LOAD_* strobe
- DISP_ALARM  out  1  display shows alarm HH:MM, seconds blanked to 0
- SET_ERR  out  1  last KEY1 entry rejected as out of range
- BUZZER_EN  out  1  buzzer drive

## Operation
- Button path: each KEY goes through a 2-FF synchronizer and a debounce counter. A 1→0 transition of the debounced level produces a one-cycle press pulse (P0, P1). Release produces nothing.
- States and MODE encoding: RUN=0, T_HOUR=1, T_MIN=2, A_HOUR=3, A_MIN=4. Other codes are unreachable and recover to RUN on the next cycle.
- P0 transitions:
  - RUN→T_HOUR if ALARM_EN=0; RUN→A_HOUR if ALARM_EN=1.
  - T_HOUR→T_MIN→RUN.
  - A_HOUR→A_MIN→RUN.
  - ALARM_EN is sampled only on the RUN exit.
- P1 in a set state validates SET_IN:
  - Hour states: tens≤2, ones≤9, and value≤0x23.
  - Minute states: tens≤5, ones≤9.
  - Valid: the matching LOAD_* pulses for one cycle, LOAD_VALUE=SET_IN, SET_ERR←0, and the state is unchanged.
  - Invalid: no strobe, SET_ERR←1.
- P1 in RUN dismisses the buzzer (BUZZER_EN←0) and leaves SET_ERR unchanged.
- P0 and P1 in the same cycle: P0 is acted on and P1 is discarded.
- SET_ERR clears on any P0.
- DISP_ALARM=1 exactly in A_HOUR and A_MIN.
- Buzzer:
  - In RUN with ALARM_EN=1, a rising edge of ALARM_MATCH sets BUZZER_EN and clears the seconds counter.
  - BUZZER_EN clears on P1 in RUN, on ALARM_EN=0, or when BUZZ_TIMEOUT_S SEC_TICKs have been counted.
  - A match edge while in any set state is ignored, and is not replayed on return to RUN.
  - Leaving RUN (P0) clears BUZZER_EN.
  - Because ALARM_MATCH stays high for the whole minute, the buzzer does not re-arm after dismiss within that minute.
- Reset (any time, including mid-debounce or mid-buzz): state RUN, MODE=0, all LOAD_*=0, LOAD_VALUE=0, DISP_ALARM=0, SET_ERR=0, BUZZER_EN=0, debounced levels=1 (released), counters=0.

## Timing
- Press latency: a KEY edge at cycle 0 gives a press pulse at cycle 2+DEBOUNCE_CYCLES (±1). Bounce shorter than DEBOUNCE_CYCLES restarts the count and generates no pulse.
- A state change is visible on MODE one cycle after P0.
- LOAD_* and LOAD_VALUE are registered and valid one cycle after P1. LOAD_VALUE holds its value until the next load.
- BUZZER_EN rises one cycle after the registered ALARM_MATCH edge. It falls one cycle after the clearing event.
- Timeout: BUZZER_EN falls one cycle after the BUZZ_TIMEOUT_S-th SEC_TICK following assertion.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
(Run with DEBOUNCE_CYCLES=4 and BUZZ_TIMEOUT_S=3.)
- Bouncing KEY0 (three 2-cycle glitches, then held low) → exactly one P0. MODE 0→1 about 6 cycles after the stable low.
- ALARM_EN=0; P0, then SET_IN=0x14 and P1 → LOAD_HOUR single pulse, LOAD_VALUE=0x14. Then P0, SET_IN=0x59, P1 → LOAD_MIN pulse. Then P0 → MODE=0.
- In T_HOUR, SET_IN=0x24, P1 → no strobe, SET_ERR=1. Then SET_IN=0x1A, P1 → SET_ERR stays 1. Then P0 → SET_ERR=0, MODE=2.
- ALARM_EN=1; P0 → MODE=3 and DISP_ALARM=1. SET_IN=0x07, P1 → LOAD_A_HOUR with 0x07. P0, P0 → MODE=0 and DISP_ALARM=0.
- RUN with ALARM_EN=1; raise ALARM_MATCH → BUZZER_EN=1. P1 → BUZZER_EN=0 and stays 0 while ALARM_MATCH remains high. Repeat without P1: after 3 SEC_TICKs, BUZZER_EN=0.
- With BUZZER_EN=1, assert RESET_N=0 for 1 cycle mid-debounce → all outputs at reset values. KEY0 and KEY1 pressed simultaneously after reset → MODE=1 and no LOAD_* pulse.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: alarm-clock mode controller. Debounces KEY0/KEY1,
// sequences time/alarm set states, issues BCD load strobes, owns the buzzer.
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   RESET_N      in   asynchronous active-low reset
//   KEY0         in   mode button, active-low, asynchronous
//   KEY1         in   set/dismiss button, active-low, asynchronous
//   ALARM_EN     in   alarm arm switch, level
//   SET_IN[7:0]  in   BCD entry value, [7:4] tens, [3:0] ones
//   SEC_TICK     in   one-cycle pulse per second
//   ALARM_MATCH  in   high while current HH:MM equals alarm HH:MM
//   MODE[2:0]    out  RUN=0 T_HOUR=1 T_MIN=2 A_HOUR=3 A_MIN=4
//   LOAD_*       out  one-cycle load strobes (hour, min, alarm hour, alarm min)
//   LOAD_VALUE   out  BCD value qualified by any LOAD_* strobe
//   DISP_ALARM   out  display shows alarm HH:MM
//   SET_ERR      out  last KEY1 entry rejected
//   BUZZER_EN    out  buzzer drive

module clock_mode_ctrl_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);

    localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // Count while the synchronized input disagrees with the accepted level;
    // any agreement (bounce back) restarts the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            s1_q <= key_i;
            s2_q <= s1_q;
            if (s2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                level_q <= s2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Press is the cycle in which the accepted level falls to 0.
    assign press_o = (s2_q != level_q) && (cnt_q == LAST) && !s2_q;

endmodule

module clock_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BUZZ_TIMEOUT_S  = 60
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY0,
    input  logic       KEY1,
    input  logic       ALARM_EN,
    input  logic [7:0] SET_IN,
    input  logic       SEC_TICK,
    input  logic       ALARM_MATCH,
    output logic [2:0] MODE,
    output logic       LOAD_HOUR,
    output logic       LOAD_MIN,
    output logic       LOAD_A_HOUR,
    output logic       LOAD_A_MIN,
    output logic [7:0] LOAD_VALUE,
    output logic       DISP_ALARM,
    output logic       SET_ERR,
    output logic       BUZZER_EN
);

    localparam int SW = (BUZZ_TIMEOUT_S < 2) ? 1 : $clog2(BUZZ_TIMEOUT_S);
    localparam logic [SW-1:0] LAST_S = SW'(BUZZ_TIMEOUT_S - 1);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        T_HOUR = 3'd1,
        T_MIN  = 3'd2,
        A_HOUR = 3'd3,
        A_MIN  = 3'd4
    } state_e;

    state_e        state_q;
    logic          load_hour_q;
    logic          load_min_q;
    logic          load_a_hour_q;
    logic          load_a_min_q;
    logic [7:0]    load_value_q;
    logic          disp_alarm_q;
    logic          set_err_q;
    logic          buzzer_q;
    logic          match_q;
    logic [SW-1:0] sec_cnt_q;

    logic p0;
    logic p1;
    logic hour_ok;
    logic min_ok;
    logic match_rise;

    clock_mode_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db0 (
        .clk_i  (CLOCK_50),
        .rst_ni (RESET_N),
        .key_i  (KEY0),
        .press_o(p0)
    );

    clock_mode_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk_i  (CLOCK_50),
        .rst_ni (RESET_N),
        .key_i  (KEY1),
        .press_o(p1)
    );

    assign hour_ok = (SET_IN[7:4] <= 4'd2) && (SET_IN[3:0] <= 4'd9)
                  && (SET_IN <= 8'h23);
    assign min_ok  = (SET_IN[7:4] <= 4'd5) && (SET_IN[3:0] <= 4'd9);

    assign match_rise = ALARM_MATCH && !match_q;

    // P0 always wins over P1 through the if/else ordering below.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= RUN;
            load_hour_q   <= 1'b0;
            load_min_q    <= 1'b0;
            load_a_hour_q <= 1'b0;
            load_a_min_q  <= 1'b0;
            load_value_q  <= 8'h00;
            disp_alarm_q  <= 1'b0;
            set_err_q     <= 1'b0;
            buzzer_q      <= 1'b0;
            match_q       <= 1'b0;
            sec_cnt_q     <= '0;
        end else begin
            load_hour_q   <= 1'b0;
            load_min_q    <= 1'b0;
            load_a_hour_q <= 1'b0;
            load_a_min_q  <= 1'b0;
            match_q       <= ALARM_MATCH;
            case (state_q)
                RUN: begin
                    if (p0) begin
                        state_q      <= ALARM_EN ? A_HOUR : T_HOUR;
                        disp_alarm_q <= ALARM_EN;
                        buzzer_q     <= 1'b0;
                        set_err_q    <= 1'b0;
                    end else if (p1 || !ALARM_EN) begin
                        buzzer_q <= 1'b0;
                    end else if (match_rise) begin
                        buzzer_q  <= 1'b1;
                        sec_cnt_q <= '0;
                    end else if (buzzer_q && SEC_TICK) begin
                        if (sec_cnt_q == LAST_S) begin
                            buzzer_q  <= 1'b0;
                            sec_cnt_q <= '0;
                        end else begin
                            sec_cnt_q <= sec_cnt_q + SW'(1);
                        end
                    end
                end
                T_HOUR: begin
                    if (p0) begin
                        state_q   <= T_MIN;
                        set_err_q <= 1'b0;
                    end else if (p1) begin
                        if (hour_ok) begin
                            load_hour_q  <= 1'b1;
                            load_value_q <= SET_IN;
                        end
                        set_err_q <= !hour_ok;
                    end
                end
                T_MIN: begin
                    if (p0) begin
                        state_q   <= RUN;
                        set_err_q <= 1'b0;
                    end else if (p1) begin
                        if (min_ok) begin
                            load_min_q   <= 1'b1;
                            load_value_q <= SET_IN;
                        end
                        set_err_q <= !min_ok;
                    end
                end
                A_HOUR: begin
                    if (p0) begin
                        state_q   <= A_MIN;
                        set_err_q <= 1'b0;
                    end else if (p1) begin
                        if (hour_ok) begin
                            load_a_hour_q <= 1'b1;
                            load_value_q  <= SET_IN;
                        end
                        set_err_q <= !hour_ok;
                    end
                end
                A_MIN: begin
                    if (p0) begin
                        state_q      <= RUN;
                        disp_alarm_q <= 1'b0;
                        set_err_q    <= 1'b0;
                    end else if (p1) begin
                        if (min_ok) begin
                            load_a_min_q <= 1'b1;
                            load_value_q <= SET_IN;
                        end
                        set_err_q <= !min_ok;
                    end
                end
                default: begin
                    state_q      <= RUN;
                    disp_alarm_q <= 1'b0;
                    buzzer_q     <= 1'b0;
                end
            endcase
        end
    end

    assign MODE        = state_q;
    assign LOAD_HOUR   = load_hour_q;
    assign LOAD_MIN    = load_min_q;
    assign LOAD_A_HOUR = load_a_hour_q;
    assign LOAD_A_MIN  = load_a_min_q;
    assign LOAD_VALUE  = load_value_q;
    assign DISP_ALARM  = disp_alarm_q;
    assign SET_ERR     = set_err_q;
    assign BUZZER_EN   = buzzer_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: directed bench for clock_mode_ctrl with a
// tag/expected scoreboard checked by immediate assertions.

module tb_clock_mode_ctrl;

    logic       clk = 1'b0;
    logic       RESET_N = 1'b1;
    logic       KEY0 = 1'b1;
    logic       KEY1 = 1'b1;
    logic       ALARM_EN = 1'b0;
    logic [7:0] SET_IN = 8'h00;
    logic       SEC_TICK = 1'b0;
    logic       ALARM_MATCH = 1'b0;
    logic [2:0] MODE;
    logic       LOAD_HOUR;
    logic       LOAD_MIN;
    logic       LOAD_A_HOUR;
    logic       LOAD_A_MIN;
    logic [7:0] LOAD_VALUE;
    logic       DISP_ALARM;
    logic       SET_ERR;
    logic       BUZZER_EN;

    clock_mode_ctrl #(.DEBOUNCE_CYCLES(4), .BUZZ_TIMEOUT_S(3)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (RESET_N),
        .KEY0       (KEY0),
        .KEY1       (KEY1),
        .ALARM_EN   (ALARM_EN),
        .SET_IN     (SET_IN),
        .SEC_TICK   (SEC_TICK),
        .ALARM_MATCH(ALARM_MATCH),
        .MODE       (MODE),
        .LOAD_HOUR  (LOAD_HOUR),
        .LOAD_MIN   (LOAD_MIN),
        .LOAD_A_HOUR(LOAD_A_HOUR),
        .LOAD_A_MIN (LOAD_A_MIN),
        .LOAD_VALUE (LOAD_VALUE),
        .DISP_ALARM (DISP_ALARM),
        .SET_ERR    (SET_ERR),
        .BUZZER_EN  (BUZZER_EN)
    );

    always #5 clk = ~clk;

    int n_lh = 0, n_lm = 0, n_lah = 0, n_lam = 0, mchg = 0;
    logic [2:0] prev_mode = 3'd0;

    always @(negedge clk) begin
        if (LOAD_HOUR)   n_lh++;
        if (LOAD_MIN)    n_lm++;
        if (LOAD_A_HOUR) n_lah++;
        if (LOAD_A_MIN)  n_lam++;
        if (MODE !== prev_mode) mchg++;
        prev_mode = MODE;
    end

    int checks = 0, errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    int b_lh, b_lm, b_lah, b_lam, b_m, lat;

    task automatic push(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic snap();
        b_lh = n_lh; b_lm = n_lm; b_lah = n_lah; b_lam = n_lam;
    endtask

    function automatic logic [31:0] strobes();
        return {8'(n_lh - b_lh), 8'(n_lm - b_lm),
                8'(n_lah - b_lah), 8'(n_lam - b_lam)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit k0, input bit k1);
        if (k0) KEY0 = 1'b0;
        if (k1) KEY1 = 1'b0;
        cyc(12);
        KEY0 = 1'b1;
        KEY1 = 1'b1;
        cyc(12);
    endtask

    task automatic sec_tick();
        SEC_TICK = 1'b1;
        cyc(1);
        SEC_TICK = 1'b0;
        cyc(2);
    endtask

    task automatic chk_reset_outs(input string t);
        push({t, "_mode"}, 0);  chk(32'(MODE));
        push({t, "_buzz"}, 0);  chk(32'(BUZZER_EN));
        push({t, "_err"}, 0);   chk(32'(SET_ERR));
        push({t, "_disp"}, 0);  chk(32'(DISP_ALARM));
        push({t, "_val"}, 0);   chk(32'(LOAD_VALUE));
        push({t, "_strb"}, 0);
        chk(32'({LOAD_HOUR, LOAD_MIN, LOAD_A_HOUR, LOAD_A_MIN}));
    endtask

    initial begin
        #2 RESET_N = 1'b0;
        cyc(3);
        chk_reset_outs("rst");
        RESET_N = 1'b1;
        cyc(2);

        // bouncing KEY0 -> exactly one press, T_HOUR
        push("bounce_mode", 1);
        push("bounce_once", 1);
        push("bounce_lat", 1);
        b_m = mchg;
        repeat (3) begin
            KEY0 = 1'b0; cyc(2);
            KEY0 = 1'b1; cyc(2);
        end
        KEY0 = 1'b0;
        lat = 0;
        while (MODE !== 3'd1 && lat < 20) begin
            cyc(1);
            lat++;
        end
        KEY0 = 1'b1;
        cyc(12);
        chk(32'(MODE));
        chk(32'(mchg - b_m));
        chk(32'(lat >= 5 && lat <= 7));

        // valid hour load 0x14
        snap();
        SET_IN = 8'h14;
        push("lh_strobe", 32'h01000000);
        push("lh_value", 32'h14);
        push("lh_mode", 1);
        push("lh_disp", 0);
        press(0, 1);
        chk(strobes());
        chk(32'(LOAD_VALUE));
        chk(32'(MODE));
        chk(32'(DISP_ALARM));

        // T_MIN, valid minute load 0x59, back to RUN
        push("tmin_mode", 2);
        press(1, 0);
        chk(32'(MODE));
        snap();
        SET_IN = 8'h59;
        push("lm_strobe", 32'h00010000);
        push("lm_value", 32'h59);
        press(0, 1);
        chk(strobes());
        chk(32'(LOAD_VALUE));
        push("tmin_run", 0);
        press(1, 0);
        chk(32'(MODE));

        // invalid hour entries
        push("t2_mode", 1);
        press(1, 0);
        chk(32'(MODE));
        snap();
        SET_IN = 8'h24;
        push("h24_err", 1);
        push("h24_strobe", 0);
        press(0, 1);
        chk(32'(SET_ERR));
        chk(strobes());
        SET_IN = 8'h1A;
        push("h1a_err", 1);
        push("h1a_strobe", 0);
        push("h1a_value_hold", 32'h59);
        press(0, 1);
        chk(32'(SET_ERR));
        chk(strobes());
        chk(32'(LOAD_VALUE));
        push("p0_err_clr", 0);
        push("p0_mode2", 2);
        press(1, 0);
        chk(32'(SET_ERR));
        chk(32'(MODE));
        snap();
        SET_IN = 8'h60;
        push("m60_err", 1);
        push("m60_strobe", 0);
        press(0, 1);
        chk(32'(SET_ERR));
        chk(strobes());
        press(1, 0);

        // alarm set path
        ALARM_EN = 1'b1;
        push("a_mode3", 3);
        push("a_disp", 1);
        press(1, 0);
        chk(32'(MODE));
        chk(32'(DISP_ALARM));
        snap();
        SET_IN = 8'h07;
        push("lah_strobe", 32'h00000100);
        push("lah_value", 32'h07);
        press(0, 1);
        chk(strobes());
        chk(32'(LOAD_VALUE));
        push("a_mode4", 4);
        press(1, 0);
        chk(32'(MODE));
        snap();
        SET_IN = 8'h45;
        push("lam_strobe", 32'h00000001);
        push("lam_value", 32'h45);
        press(0, 1);
        chk(strobes());
        chk(32'(LOAD_VALUE));
        push("a_run", 0);
        push("a_disp_off", 0);
        press(1, 0);
        chk(32'(MODE));
        chk(32'(DISP_ALARM));

        // buzzer: dismiss, no re-arm while match held
        push("buzz_on", 1);
        ALARM_MATCH = 1'b1;
        cyc(3);
        chk(32'(BUZZER_EN));
        push("buzz_dismiss", 0);
        push("buzz_stays_off", 0);
        push("dismiss_err", 0);
        press(0, 1);
        chk(32'(BUZZER_EN));
        cyc(10);
        chk(32'(BUZZER_EN));
        chk(32'(SET_ERR));

        // buzzer timeout after 3 ticks
        ALARM_MATCH = 1'b0;
        cyc(2);
        push("buzz2_on", 1);
        push("buzz2_2ticks", 1);
        push("buzz2_timeout", 0);
        ALARM_MATCH = 1'b1;
        cyc(3);
        chk(32'(BUZZER_EN));
        sec_tick();
        sec_tick();
        chk(32'(BUZZER_EN));
        sec_tick();
        chk(32'(BUZZER_EN));

        // ALARM_EN low clears buzzer
        ALARM_MATCH = 1'b0;
        cyc(2);
        push("buzz3_on", 1);
        push("buzz3_en_off", 0);
        ALARM_MATCH = 1'b1;
        cyc(3);
        chk(32'(BUZZER_EN));
        ALARM_EN = 1'b0;
        cyc(2);
        chk(32'(BUZZER_EN));
        ALARM_EN = 1'b1;
        ALARM_MATCH = 1'b0;
        cyc(2);

        // match edge during set state is ignored and not replayed
        push("set_mode3", 3);
        press(1, 0);
        chk(32'(MODE));
        ALARM_MATCH = 1'b1;
        push("set_no_buzz", 0);
        cyc(3);
        chk(32'(BUZZER_EN));
        press(1, 0);
        push("replay_run", 0);
        push("no_replay", 0);
        press(1, 0);
        chk(32'(MODE));
        chk(32'(BUZZER_EN));
        ALARM_MATCH = 1'b0;
        cyc(2);

        // reset mid-buzz and mid-debounce
        push("buzz4_on", 1);
        ALARM_MATCH = 1'b1;
        cyc(3);
        chk(32'(BUZZER_EN));
        KEY0 = 1'b0;
        cyc(3);
        ALARM_MATCH = 1'b0;
        RESET_N = 1'b0;
        #2;
        chk_reset_outs("midrst");
        cyc(1);
        RESET_N = 1'b1;
        KEY0 = 1'b1;
        cyc(12);
        push("post_rst_mode", 0);
        chk(32'(MODE));

        // simultaneous presses: P0 wins, P1 discarded
        ALARM_EN = 1'b0;
        SET_IN = 8'h12;
        snap();
        push("both_mode", 1);
        push("both_strobe", 0);
        push("both_err", 0);
        press(1, 1);
        chk(32'(MODE));
        chk(strobes());
        chk(32'(SET_ERR));

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0",
                   exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
